// File: rtl/conv_pkg.sv
// Shared definitions for the decimal conversion datapath: the converter
// state encoding, BCD digit constants and a digit-validity helper.
package conv_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Width of one packed BCD digit.
    localparam int BCD_NIBBLE_W = 4;

    // Largest legal decimal digit value.
    localparam logic [BCD_NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;

    // True when a nibble does not encode a decimal digit (10..15).
    function automatic logic bcd_digit_bad(input logic [BCD_NIBBLE_W-1:0] d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One decimal fold step: next = acc*10 + d, kept at BIN_W+4 bits so that the
// bits above BIN_W expose any overflow of the step. Also flags a non-decimal
// nibble. The nibble is added at its raw value even when it is invalid.
module bcd_mac10
    import conv_pkg::*;
#(
    parameter int BIN_W = 32
) (
    input  logic [BIN_W-1:0]        acc,
    input  logic [BCD_NIBBLE_W-1:0] d,
    output logic [BIN_W+3:0]        next,
    output logic                    digit_bad
);

    logic [BIN_W+3:0] acc_ext_s;
    logic [BIN_W+3:0] d_ext_s;
    logic [BIN_W+3:0] acc_x8_s;
    logic [BIN_W+3:0] acc_x2_s;

    assign acc_ext_s = {4'b0000, acc};
    assign d_ext_s   = {{BIN_W{1'b0}}, d};

    // acc*10 built from two shifts; (2^BIN_W-1)*10+15 fits in BIN_W+4 bits,
    // so this sum can never wrap.
    assign acc_x8_s  = acc_ext_s << 2'd3;
    assign acc_x2_s  = acc_ext_s << 2'd1;
    assign next      = acc_x8_s + acc_x2_s + d_ext_s;

    assign digit_bad = bcd_digit_bad(d);

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned-binary converter. A word is accepted over
// a valid/ready handshake, folded into binary one digit per clock (most
// significant digit first, acc = acc*10 + digit), and the BIN_W-bit result is
// returned with sticky overflow and invalid-digit flags over a second
// valid/ready handshake.
module bcd_to_binary
    import conv_pkg::*;
#(
    parameter int DIGITS = 10,
    parameter int BIN_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BIN_W-1:0]            bin,
    output logic                        ovf,
    output logic                        err
);

    localparam int SR_W  = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    conv_state_e             state_r;
    conv_state_e             state_s;

    // Working registers of the fold.
    logic [SR_W-1:0]         sreg_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [BIN_W-1:0]        acc_r;
    logic                    ovf_acc_r;
    logic                    err_acc_r;

    // Result registers presented on the output handshake.
    logic [BIN_W-1:0]        bin_r;
    logic                    ovf_r;
    logic                    err_r;

    // Combinational step results.
    logic [BCD_NIBBLE_W-1:0] digit_s;
    logic [BIN_W+3:0]        next_s;
    logic                    digit_bad_s;
    logic                    ovf_step_s;
    logic                    err_step_s;
    logic                    last_digit_s;

    assign digit_s      = sreg_r[SR_W-1 -: BCD_NIBBLE_W];
    assign last_digit_s = (cnt_r == CNT_ZERO);

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .acc       (acc_r),
        .d         (digit_s),
        .next      (next_s),
        .digit_bad (digit_bad_s)
    );

    // Overflow is sticky: any step that carries past BIN_W bits latches it.
    assign ovf_step_s = ovf_acc_r | (|next_s[BIN_W+3:BIN_W]);
    assign err_step_s = err_acc_r | digit_bad_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: accept in IDLE, fold DIGITS digits, wait for consumer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (last_digit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Fold datapath: load on accept, one digit per CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r    <= {SR_W{1'b0}};
            cnt_r     <= CNT_ZERO;
            acc_r     <= {BIN_W{1'b0}};
            ovf_acc_r <= 1'b0;
            err_acc_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sreg_r    <= bcd;
                        cnt_r     <= CNT_LOAD;
                        acc_r     <= {BIN_W{1'b0}};
                        ovf_acc_r <= 1'b0;
                        err_acc_r <= 1'b0;
                    end
                end
                CONV: begin
                    acc_r     <= next_s[BIN_W-1:0];
                    ovf_acc_r <= ovf_step_s;
                    err_acc_r <= err_step_s;
                    sreg_r    <= {sreg_r[SR_W-BCD_NIBBLE_W-1:0], {BCD_NIBBLE_W{1'b0}}};
                    if (!last_digit_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: updated only on the edge that enters DONE, so they
    // stay stable through backpressure and hold their value in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r <= {BIN_W{1'b0}};
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else if ((state_r == CONV) && last_digit_s) begin
            bin_r <= next_s[BIN_W-1:0];
            ovf_r <= ovf_step_s;
            err_r <= err_step_s;
        end
    end

    // Handshake flags come straight from the state register; they are
    // mutually exclusive by construction.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bin       = bin_r;
    assign ovf       = ovf_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed table, random words against
// an arithmetic reference model, backpressure and mid-conversion reset.
module tb_bcd_to_binary;

    localparam int DIGITS = 10;
    localparam int BIN_W  = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin;
    logic                  ovf;
    logic                  err;

    int checks;
    int failures;

    bcd_to_binary #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] word;
        logic [31:0] exp_bin;
        logic        exp_ovf;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: evaluate the decimal number with wide integer arithmetic.
    function automatic void model(input logic [39:0] w, output logic [31:0] b,
                                  output logic o, output logic e);
        logic [63:0] v;
        logic [3:0]  n;
        v = 64'd0;
        e = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            n = w[4*k +: 4];
            v = v * 64'd10 + {60'd0, n};
            if (n > 4'd9) e = 1'b1;
        end
        b = v[31:0];
        o = (v > 64'h0000_0000_FFFF_FFFF);
    endfunction

    // Present a word, wait for out_valid (bounded); leaves DONE un-acked.
    task automatic start_and_wait(input logic [39:0] w, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        bcd      = w;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            failures++;
            $display("FAIL timeout waiting for out_valid word=%0h", w);
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [39:0] w, input logic [31:0] eb,
                             input logic eo, input logic ee, input logic chk_lat);
        int lat;
        start_and_wait(w, lat);
        if (chk_lat) chk({name, "_latency"}, 64'(lat), 64'd10);
        chk({name, "_bin"}, {32'd0, bin}, {32'd0, eb});
        chk({name, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        chk({name, "_err"}, {63'd0, err}, {63'd0, ee});
        chk({name, "_in_ready_low"}, {63'd0, in_ready}, 64'd0);
        ack();
    endtask

    initial begin
        logic [39:0] w;
        logic [31:0] mb;
        logic        mo;
        logic        me;
        logic [3:0]  nib;
        int          lat;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd       = 40'd0;

        vecs[0] = '{40'h00_0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{40'h42_9496_7295, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2] = '{40'h42_9496_7296, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{40'h99_9999_9999, 32'h540B_E3FF, 1'b1, 1'b0};
        vecs[4] = '{40'h00_0000_00A5, 32'd105,       1'b0, 1'b1};
        vecs[5] = '{40'h00_0012_3456, 32'd123456,    1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_bin",       {32'd0, bin},       64'd0);
        chk("reset_ovf",       {63'd0, ovf},       64'd0);
        chk("reset_err",       {63'd0, err},       64'd0);

        for (int i = 0; i < 6; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp_bin,
                      vecs[i].exp_ovf, vecs[i].exp_err, 1'b1);
        end

        // Random words, occasionally with non-decimal nibbles.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < DIGITS; k++) begin
                if ($urandom_range(0, 7) == 0) nib = 4'($urandom_range(10, 15));
                else nib = 4'($urandom_range(0, 9));
                w[4*k +: 4] = nib;
            end
            model(w, mb, mo, me);
            run_check($sformatf("rand%0d", r), w, mb, mo, me, 1'b0);
        end

        // Backpressure: result held, in_valid ignored while DONE.
        start_and_wait(40'h00_0000_1234, lat);
        for (int c = 0; c < 5; c++) begin
            chk("bp_bin",       {32'd0, bin},       64'd1234);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready",  {63'd0, in_ready},  64'd0);
            bcd      = 40'h00_0000_0077;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_in_ready_after_ack", {63'd0, in_ready},  64'd1);
        chk("bp_out_valid_after",    {63'd0, out_valid}, 64'd0);
        chk("bp_bin_held_idle",      {32'd0, bin},       64'd1234);

        // Reset during the 4th CONV cycle.
        bcd      = 40'h99_9999_9999;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_busy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_bin",       {32'd0, bin},       64'd0);
        chk("midreset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("midreset_ovf",       {63'd0, ovf},       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_reset", 40'h00_0000_0042, 32'd42, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
